idma_obi_read_outstanding: RTL and testbench
============================================

Name: idma_obi_read_outstanding

Overview:
- Multi-outstanding OBI read port for the iDMA transport layer, one stage upstream of the read barrel shifter and dataflow buffer.
- Issues one word-aligned OBI read per read-meta beat and keeps up to NumOutstanding reads in flight.
- Captures every rvalid into a response FIFO, because OBI has no response back-pressure.
- Releases bytes to the buffer under a per-beat offset/tailer byte mask, and returns one error-accumulated read-datapath response per transfer.

Parameters:
DataWidth, 32, bus data width in bits; power of two, at least 16.
AddrWidth, 32, address width in bits.
NumOutstanding, 4, maximum number of granted reads whose data is not yet consumed; also the response FIFO depth.
StrbWidth, DataWidth/8, bytes per beat (derived).
OffsetWidth, $clog2(StrbWidth), byte offset width (derived).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
meta_addr_i  in  AddrWidth  read address of one beat
meta_valid_i  in  1  meta beat valid
meta_ready_o  out  1  meta beat accepted
dp_offset_i  in  OffsetWidth  first valid byte lane of the current beat
dp_tailer_i  in  OffsetWidth  number of invalid top byte lanes of the current beat
dp_last_i  in  1  current beat is the last beat of the transfer
dp_valid_i  in  1  beat descriptor valid
dp_ready_o  out  1  beat descriptor consumed
obi_req_o  out  1  OBI request
obi_addr_o  out  AddrWidth  meta_addr_i with the low OffsetWidth bits cleared
obi_we_o  out  1  constant 0
obi_be_o  out  StrbWidth  constant all ones
obi_gnt_i  in  1  OBI grant
obi_rvalid_i  in  1  OBI response valid
obi_rdata_i  in  DataWidth  OBI read data
obi_err_i  in  1  OBI response error
buffer_in_o  out  DataWidth  FIFO head data, unshifted
buffer_in_valid_o  out  StrbWidth  per-byte valid toward the buffer
buffer_in_ready_i  in  StrbWidth  per-byte ready from the buffer
rsp_err_o  out  1  transfer saw at least one OBI error
rsp_valid_o  out  1  transfer response valid
rsp_ready_i  in  1  transfer response accepted
busy_o  out  1  reads in flight or response pending

Behaviour:
- Reset (asynchronous, active-low). Clears: inflight counter, FIFO pointers, byte-done mask, sticky error and rsp_valid_o.
  - During and after reset: obi_req_o, meta_ready_o, dp_ready_o, buffer_in_valid_o, rsp_valid_o and busy_o are all 0.
- Inflight counter (width $clog2(NumOutstanding+1)):
  - Increments on obi_req_o && obi_gnt_i.
  - Decrements when a beat completes, i.e. its FIFO entry is popped.
  - Both events in the same cycle leave it unchanged.
- Request side:
  - obi_req_o = meta_valid_i && (inflight < NumOutstanding).
  - meta_ready_o = obi_req_o && obi_gnt_i.
  - At inflight == NumOutstanding: obi_req_o = 0, and meta_valid_i is held off.
  - Request signals are combinational from meta; zero added latency.
- Response FIFO:
  - Every obi_rvalid_i pushes {rdata, err}; the push is unconditional.
  - FIFO space is guaranteed by the inflight limit.
  - A push when full, or an rvalid with inflight == 0, is a protocol violation and is covered by a simulation assertion.
  - Data written in cycle N is visible at the head in cycle N+1 (registered FIFO, no fall-through).
- Byte mask: lane i is set iff i >= dp_offset_i and i < StrbWidth - dp_tailer_i. If dp_offset_i + dp_tailer_i >= StrbWidth, the mask is empty.
- Delivery (active when the FIFO is non-empty and dp_valid_i = 1):
  - buffer_in_valid_o = mask & ~done.
  - done |= buffer_in_valid_o & buffer_in_ready_i each cycle.
  - Lanes may be accepted across several cycles in any order.
  - While the FIFO is empty or dp_valid_i = 0, buffer_in_valid_o = 0.
- Beat completion:
  - Condition: (done | (valid & ready)) covers the mask. An empty mask completes in the first eligible cycle.
  - Extra condition when dp_last_i = 1: !rsp_valid_o || rsp_ready_i.
  - On completion in the same cycle: FIFO pop, dp_ready_o = 1, done cleared, head error ORed into the sticky error.
- Response:
  - Completion of a last beat loads rsp_err_o = sticky | head error, sets rsp_valid_o and clears the sticky error.
  - rsp_valid_o is held until rsp_ready_i.
  - A new last beat may complete in the cycle the previous response is accepted; the register reloads back-to-back.
- Errors do not abort the transfer; data is still forwarded.
- busy_o = (inflight != 0) || rsp_valid_o.
- Reset mid-transfer drops all state immediately. OBI responses still pending in the fabric afterwards are a system-level violation.

Test Plan:
- Single beat, DataWidth 32, addr 0x1003, offset 0, tailer 0, last 1, gnt immediate, rvalid next cycle with 0xDDCCBBAA, ready all ones.
  -> obi_addr_o = 0x1000; buffer_in_valid_o = 4'b1111 one cycle after rvalid; dp_ready_o pulses; rsp_valid_o = 1 with err 0 on the following edge.
- Outstanding limit: NumOutstanding 4, 6 meta beats, gnt always 1, rvalid withheld.
  -> exactly 4 grants, obi_req_o = 0 afterwards; the 5th request appears the cycle after the first beat completes.
- Partial lanes: offset 1, tailer 1, buffer_in_ready_i = 4'b0010, then 4'b0100.
  -> valid 4'b0110, then 4'b0100; completion only in the second cycle; lanes 0 and 3 never asserted.
- Error accumulation: 3-beat transfer, obi_err_i = 1 on beat 2 only.
  -> single response with rsp_err_o = 1; the next transfer's response has rsp_err_o = 0.
- Response back-pressure: two 1-beat transfers, rsp_ready_i = 0 for 5 cycles.
  -> second beat is not completed (dp_ready_o = 0) until the cycle rsp_ready_i = 1; responses are emitted back-to-back.
- Empty mask and reset: offset 2, tailer 2 completes without asserting buffer_in_valid_o. rst_ni low with inflight 3 -> all outputs 0 and busy_o = 0 immediately.

Source files
------------

// File: rtl/idma_obi_read_outstanding.sv
// idma_obi_read_outstanding
//   Multi-outstanding OBI read port for the iDMA transport layer. It issues
//   one word-aligned OBI read per meta beat and keeps up to NumOutstanding
//   reads in flight. Every rvalid is captured into a response FIFO, because
//   OBI cannot stall responses. FIFO head bytes are released to the dataflow
//   buffer under a per-beat offset/tailer mask. One error-accumulated response
//   is returned per transfer.
//
// Ports
//   clk_i, rst_ni                      clock, async active-low reset
//   meta_addr_i/valid_i, meta_ready_o  per-beat read address
//   dp_offset_i/tailer_i/last_i        per-beat byte window and last flag
//   dp_valid_i, dp_ready_o             beat descriptor handshake (ready = beat done)
//   obi_req_o/addr_o/we_o/be_o         OBI request channel
//   obi_gnt_i                          OBI grant
//   obi_rvalid_i/rdata_i/err_i         OBI response channel (no back-pressure)
//   buffer_in_o/valid_o, ready_i       per-byte handshake toward the buffer
//   rsp_err_o/valid_o, rsp_ready_i     per-transfer response
//   busy_o                             reads in flight or response pending
module idma_obi_read_outstanding #(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned NumOutstanding = 4,
  parameter int unsigned StrbWidth      = DataWidth / 8,
  parameter int unsigned OffsetWidth    = $clog2(StrbWidth)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AddrWidth-1:0]   meta_addr_i,
  input  logic                   meta_valid_i,
  output logic                   meta_ready_o,
  input  logic [OffsetWidth-1:0] dp_offset_i,
  input  logic [OffsetWidth-1:0] dp_tailer_i,
  input  logic                   dp_last_i,
  input  logic                   dp_valid_i,
  output logic                   dp_ready_o,
  output logic                   obi_req_o,
  output logic [AddrWidth-1:0]   obi_addr_o,
  output logic                   obi_we_o,
  output logic [StrbWidth-1:0]   obi_be_o,
  input  logic                   obi_gnt_i,
  input  logic                   obi_rvalid_i,
  input  logic [DataWidth-1:0]   obi_rdata_i,
  input  logic                   obi_err_i,
  output logic [DataWidth-1:0]   buffer_in_o,
  output logic [StrbWidth-1:0]   buffer_in_valid_o,
  input  logic [StrbWidth-1:0]   buffer_in_ready_i,
  output logic                   rsp_err_o,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic                   busy_o
);

  localparam int unsigned CntWidth = $clog2(NumOutstanding + 1);
  localparam int unsigned PtrWidth = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
  localparam logic [CntWidth-1:0]  MaxCnt    = CntWidth'(NumOutstanding);
  localparam logic [PtrWidth-1:0]  LastPtr   = PtrWidth'(NumOutstanding - 1);
  localparam logic [AddrWidth-1:0] AlignMask = ~(AddrWidth'(StrbWidth - 1));

  logic [CntWidth-1:0]  inflight_q, inflight_d;
  logic [CntWidth-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DataWidth-1:0] data_q [NumOutstanding];
  logic [DataWidth-1:0] data_d [NumOutstanding];
  logic [NumOutstanding-1:0] err_q, err_d;
  logic [StrbWidth-1:0] done_q, done_d;
  logic                 sticky_err_q, sticky_err_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 rsp_valid_q, rsp_valid_d;

  logic [StrbWidth-1:0] mask;
  logic [StrbWidth-1:0] accepted;
  logic                 grant, push, pop;
  logic                 fifo_empty, active, covered, rsp_free;
  logic                 head_err;

  // Request side is purely combinational from meta. Gating with rst_ni keeps
  // the request low while reset is held, even with meta_valid_i asserted.
  assign obi_req_o    = rst_ni && meta_valid_i && (inflight_q < MaxCnt);
  assign grant        = obi_req_o && obi_gnt_i;
  assign meta_ready_o = grant;
  assign obi_addr_o   = meta_addr_i & AlignMask;
  assign obi_we_o     = 1'b0;
  assign obi_be_o     = '1;

  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(StrbWidth); i++) begin
      mask[i] = (i >= int'(dp_offset_i)) && (i < int'(StrbWidth) - int'(dp_tailer_i));
    end
  end

  assign fifo_empty        = (fifo_cnt_q == '0);
  assign head_err          = err_q[rd_ptr_q];
  assign buffer_in_o       = data_q[rd_ptr_q];
  assign active            = !fifo_empty && dp_valid_i;
  assign buffer_in_valid_o = active ? (mask & ~done_q) : '0;
  assign accepted          = buffer_in_valid_o & buffer_in_ready_i;
  // An empty mask is trivially covered, so such a beat retires at once.
  assign covered           = (((done_q | accepted) & mask) == mask);
  // A last beat may only retire when the response register can take it.
  assign rsp_free          = !rsp_valid_q || rsp_ready_i;
  assign pop               = active && covered && (!dp_last_i || rsp_free);
  assign push              = obi_rvalid_i;
  assign dp_ready_o        = pop;

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = (inflight_q != '0) || rsp_valid_q;

  always_comb begin
    inflight_d = inflight_q;
    if (grant && !pop) begin
      inflight_d = inflight_q + CntWidth'(1);
    end else if (!grant && pop) begin
      inflight_d = inflight_q - CntWidth'(1);
    end
  end

  always_comb begin
    data_d     = data_q;
    err_d      = err_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      data_d[wr_ptr_q] = obi_rdata_i;
      err_d[wr_ptr_q]  = obi_err_i;
      wr_ptr_d         = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrWidth'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrWidth'(1);
    end
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + CntWidth'(1);
    end else if (!push && pop) begin
      fifo_cnt_d = fifo_cnt_q - CntWidth'(1);
    end
  end

  always_comb begin
    done_d       = done_q | accepted;
    sticky_err_d = sticky_err_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_err_d    = rsp_err_q;
    if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
    if (pop) begin
      done_d = '0;
      if (dp_last_i) begin
        rsp_valid_d  = 1'b1;
        rsp_err_d    = sticky_err_q | head_err;
        sticky_err_d = 1'b0;
      end else begin
        sticky_err_d = sticky_err_q | head_err;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q   <= '0;
      fifo_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      data_q       <= '{default: '0};
      err_q        <= '0;
      done_q       <= '0;
      sticky_err_q <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
    end else begin
      inflight_q   <= inflight_d;
      fifo_cnt_q   <= fifo_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      data_q       <= data_d;
      err_q        <= err_d;
      done_q       <= done_d;
      sticky_err_q <= sticky_err_d;
      rsp_err_q    <= rsp_err_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  // A response must belong to a granted read, and the inflight limit means
  // the FIFO can never be full when one arrives.
  rvalid_legal_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    obi_rvalid_i |-> ((inflight_q != '0) && (fifo_cnt_q != MaxCnt)));

endmodule

// File: tb/tb_idma_obi_read_outstanding.sv
module tb_idma_obi_read_outstanding;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NO = 4;
  localparam int SW = 4;
  localparam int OW = 2;

  logic          clk_i;
  logic          rst_ni;
  logic [AW-1:0] meta_addr_i;
  logic          meta_valid_i;
  logic          meta_ready_o;
  logic [OW-1:0] dp_offset_i;
  logic [OW-1:0] dp_tailer_i;
  logic          dp_last_i;
  logic          dp_valid_i;
  logic          dp_ready_o;
  logic          obi_req_o;
  logic [AW-1:0] obi_addr_o;
  logic          obi_we_o;
  logic [SW-1:0] obi_be_o;
  logic          obi_gnt_i;
  logic          obi_rvalid_i;
  logic [DW-1:0] obi_rdata_i;
  logic          obi_err_i;
  logic [DW-1:0] buffer_in_o;
  logic [SW-1:0] buffer_in_valid_o;
  logic [SW-1:0] buffer_in_ready_i;
  logic          rsp_err_o;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic          busy_o;

  int n_cmp = 0;
  int n_mis = 0;

  idma_obi_read_outstanding #(
    .DataWidth(DW), .AddrWidth(AW), .NumOutstanding(NO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .meta_addr_i(meta_addr_i), .meta_valid_i(meta_valid_i), .meta_ready_o(meta_ready_o),
    .dp_offset_i(dp_offset_i), .dp_tailer_i(dp_tailer_i), .dp_last_i(dp_last_i),
    .dp_valid_i(dp_valid_i), .dp_ready_o(dp_ready_o),
    .obi_req_o(obi_req_o), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o), .obi_be_o(obi_be_o),
    .obi_gnt_i(obi_gnt_i), .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i),
    .obi_err_i(obi_err_i),
    .buffer_in_o(buffer_in_o), .buffer_in_valid_o(buffer_in_valid_o),
    .buffer_in_ready_i(buffer_in_ready_i),
    .rsp_err_o(rsp_err_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .busy_o(busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    meta_valid_i      = 1'b0;
    meta_addr_i       = '0;
    dp_valid_i        = 1'b0;
    dp_offset_i       = '0;
    dp_tailer_i       = '0;
    dp_last_i         = 1'b0;
    obi_gnt_i         = 1'b0;
    obi_rvalid_i      = 1'b0;
    obi_rdata_i       = '0;
    obi_err_i         = 1'b0;
    buffer_in_ready_i = '1;
    rsp_ready_i       = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle_inputs();
    meta_valid_i = 1'b1;
    meta_addr_i  = 32'h40;
    obi_gnt_i    = 1'b1;
    dp_valid_i   = 1'b1;
    #3;
    n_cmp++; if (obi_req_o !== 1'b0) begin n_mis++; $display("FAIL rst_req: got %b exp 0", obi_req_o); end
    n_cmp++; if (meta_ready_o !== 1'b0) begin n_mis++; $display("FAIL rst_meta_ready: got %b exp 0", meta_ready_o); end
    n_cmp++; if (dp_ready_o !== 1'b0) begin n_mis++; $display("FAIL rst_dp_ready: got %b exp 0", dp_ready_o); end
    n_cmp++; if (buffer_in_valid_o !== 4'b0000) begin n_mis++; $display("FAIL rst_buf_valid: got %b exp 0000", buffer_in_valid_o); end
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_mis++; $display("FAIL rst_rsp_valid: got %b exp 0", rsp_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL rst_busy: got %b exp 0", busy_o); end
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++; if (obi_req_o !== 1'b0) begin n_mis++; $display("FAIL rst_req_held: got %b exp 0", obi_req_o); end
    idle_inputs();
    rst_ni = 1'b1;
    #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL post_rst_busy: got %b exp 0", busy_o); end
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_mis++; $display("FAIL post_rst_rsp_valid: got %b exp 0", rsp_valid_o); end
  endtask

  task automatic test_single_beat();
    cyc();
    meta_valid_i = 1'b1; meta_addr_i = 32'h1003; obi_gnt_i = 1'b1;
    dp_valid_i = 1'b1; dp_offset_i = 2'd0; dp_tailer_i = 2'd0; dp_last_i = 1'b1;
    #1;
    n_cmp++; if (obi_req_o !== 1'b1) begin n_mis++; $display("FAIL single_req: got %b exp 1", obi_req_o); end
    n_cmp++; if (obi_addr_o !== 32'h1000) begin n_mis++; $display("FAIL single_addr: got %h exp 00001000", obi_addr_o); end
    n_cmp++; if (meta_ready_o !== 1'b1) begin n_mis++; $display("FAIL single_meta_ready: got %b exp 1", meta_ready_o); end
    n_cmp++; if (obi_we_o !== 1'b0) begin n_mis++; $display("FAIL single_we: got %b exp 0", obi_we_o); end
    n_cmp++; if (obi_be_o !== 4'hf) begin n_mis++; $display("FAIL single_be: got %h exp f", obi_be_o); end
    n_cmp++; if (buffer_in_valid_o !== 4'b0000) begin n_mis++; $display("FAIL single_valid_early: got %b exp 0000", buffer_in_valid_o); end
    cyc();
    meta_valid_i = 1'b0; obi_gnt_i = 1'b0;
    obi_rvalid_i = 1'b1; obi_rdata_i = 32'hDDCCBBAA; obi_err_i = 1'b0;
    #1;
    n_cmp++; if (buffer_in_valid_o !== 4'b0000) begin n_mis++; $display("FAIL single_no_fallthrough: got %b exp 0000", buffer_in_valid_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_mis++; $display("FAIL single_busy: got %b exp 1", busy_o); end
    cyc();
    obi_rvalid_i = 1'b0;
    #1;
    n_cmp++; if (buffer_in_valid_o !== 4'b1111) begin n_mis++; $display("FAIL single_valid: got %b exp 1111", buffer_in_valid_o); end
    n_cmp++; if (buffer_in_o !== 32'hDDCCBBAA) begin n_mis++; $display("FAIL single_data: got %h exp ddccbbaa", buffer_in_o); end
    n_cmp++; if (dp_ready_o !== 1'b1) begin n_mis++; $display("FAIL single_dp_ready: got %b exp 1", dp_ready_o); end
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_mis++; $display("FAIL single_rsp_early: got %b exp 0", rsp_valid_o); end
    cyc();
    #1;
    n_cmp++; if (rsp_valid_o !== 1'b1) begin n_mis++; $display("FAIL single_rsp_valid: got %b exp 1", rsp_valid_o); end
    n_cmp++; if (rsp_err_o !== 1'b0) begin n_mis++; $display("FAIL single_rsp_err: got %b exp 0", rsp_err_o); end
    n_cmp++; if (dp_ready_o !== 1'b0) begin n_mis++; $display("FAIL single_dp_ready_after: got %b exp 0", dp_ready_o); end
    rsp_ready_i = 1'b1;
    cyc();
    rsp_ready_i = 1'b0; dp_valid_i = 1'b0; dp_last_i = 1'b0;
    #1;
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_mis++; $display("FAIL single_rsp_cleared: got %b exp 0", rsp_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL single_idle: got %b exp 0", busy_o); end
  endtask

  task automatic test_outstanding();
    int grants;
    grants = 0;
    cyc();
    meta_valid_i = 1'b1; meta_addr_i = 32'h2000; obi_gnt_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (obi_req_o && obi_gnt_i) grants++;
      cyc();
    end
    #1;
    n_cmp++; if (grants !== 4) begin n_mis++; $display("FAIL outst_grants: got %0d exp 4", grants); end
    n_cmp++; if (obi_req_o !== 1'b0) begin n_mis++; $display("FAIL outst_req_blocked: got %b exp 0", obi_req_o); end
    n_cmp++; if (meta_ready_o !== 1'b0) begin n_mis++; $display("FAIL outst_meta_blocked: got %b exp 0", meta_ready_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_mis++; $display("FAIL outst_busy: got %b exp 1", busy_o); end
    cyc();
    obi_rvalid_i = 1'b1; obi_rdata_i = 32'h11111111;
    dp_valid_i = 1'b1; dp_last_i = 1'b0;
    #1;
    n_cmp++; if (obi_req_o !== 1'b0) begin n_mis++; $display("FAIL outst_req_rvalid: got %b exp 0", obi_req_o); end
    n_cmp++; if (dp_ready_o !== 1'b0) begin n_mis++; $display("FAIL outst_dp_empty: got %b exp 0", dp_ready_o); end
    cyc();
    obi_rvalid_i = 1'b0;
    #1;
    n_cmp++; if (dp_ready_o !== 1'b1) begin n_mis++; $display("FAIL outst_complete: got %b exp 1", dp_ready_o); end
    n_cmp++; if (obi_req_o !== 1'b0) begin n_mis++; $display("FAIL outst_req_same_cycle: got %b exp 0", obi_req_o); end
    cyc();
    #1;
    n_cmp++; if (obi_req_o !== 1'b1) begin n_mis++; $display("FAIL outst_fifth_req: got %b exp 1", obi_req_o); end
    n_cmp++; if (meta_ready_o !== 1'b1) begin n_mis++; $display("FAIL outst_fifth_ready: got %b exp 1", meta_ready_o); end
    cyc();
    meta_valid_i = 1'b0; obi_gnt_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      obi_rvalid_i = (i < 4);
      obi_rdata_i  = 32'(i);
      cyc();
    end
    obi_rvalid_i = 1'b0; dp_valid_i = 1'b0;
    #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL outst_drained: got %b exp 0", busy_o); end
  endtask

  task automatic test_partial_lanes();
    cyc();
    meta_valid_i = 1'b1; meta_addr_i = 32'h3001; obi_gnt_i = 1'b1;
    cyc();
    meta_valid_i = 1'b0; obi_gnt_i = 1'b0;
    obi_rvalid_i = 1'b1; obi_rdata_i = 32'h44332211;
    cyc();
    obi_rvalid_i = 1'b0;
    dp_valid_i = 1'b1; dp_offset_i = 2'd1; dp_tailer_i = 2'd1; dp_last_i = 1'b0;
    buffer_in_ready_i = 4'b0010;
    #1;
    n_cmp++; if (buffer_in_valid_o !== 4'b0110) begin n_mis++; $display("FAIL partial_valid1: got %b exp 0110", buffer_in_valid_o); end
    n_cmp++; if (dp_ready_o !== 1'b0) begin n_mis++; $display("FAIL partial_no_complete: got %b exp 0", dp_ready_o); end
    cyc();
    buffer_in_ready_i = 4'b0100;
    #1;
    n_cmp++; if (buffer_in_valid_o !== 4'b0100) begin n_mis++; $display("FAIL partial_valid2: got %b exp 0100", buffer_in_valid_o); end
    n_cmp++; if (dp_ready_o !== 1'b1) begin n_mis++; $display("FAIL partial_complete: got %b exp 1", dp_ready_o); end
    cyc();
    buffer_in_ready_i = '1;
    #1;
    n_cmp++; if (buffer_in_valid_o !== 4'b0000) begin n_mis++; $display("FAIL partial_after: got %b exp 0000", buffer_in_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL partial_idle: got %b exp 0", busy_o); end
    dp_valid_i = 1'b0; dp_offset_i = 2'd0; dp_tailer_i = 2'd0;
  endtask

  task automatic test_error_accum();
    cyc();
    meta_valid_i = 1'b1; meta_addr_i = 32'h4000; obi_gnt_i = 1'b1;
    dp_valid_i = 1'b1; dp_last_i = 1'b0;
    cyc();
    meta_addr_i = 32'h4004;
    obi_rvalid_i = 1'b1; obi_rdata_i = 32'hA0A0A0A0; obi_err_i = 1'b0;
    cyc();
    meta_addr_i = 32'h4008;
    obi_rdata_i = 32'hA1A1A1A1; obi_err_i = 1'b1;
    #1;
    n_cmp++; if (dp_ready_o !== 1'b1) begin n_mis++; $display("FAIL err_beat0: got %b exp 1", dp_ready_o); end
    cyc();
    meta_valid_i = 1'b0; obi_gnt_i = 1'b0;
    obi_rdata_i = 32'hA2A2A2A2; obi_err_i = 1'b0;
    #1;
    n_cmp++; if (buffer_in_o !== 32'hA1A1A1A1) begin n_mis++; $display("FAIL err_beat1_data: got %h exp a1a1a1a1", buffer_in_o); end
    n_cmp++; if (dp_ready_o !== 1'b1) begin n_mis++; $display("FAIL err_beat1: got %b exp 1", dp_ready_o); end
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_mis++; $display("FAIL err_no_early_rsp: got %b exp 0", rsp_valid_o); end
    cyc();
    obi_rvalid_i = 1'b0; dp_last_i = 1'b1;
    #1;
    n_cmp++; if (buffer_in_o !== 32'hA2A2A2A2) begin n_mis++; $display("FAIL err_beat2_data: got %h exp a2a2a2a2", buffer_in_o); end
    n_cmp++; if (dp_ready_o !== 1'b1) begin n_mis++; $display("FAIL err_beat2: got %b exp 1", dp_ready_o); end
    cyc();
    dp_valid_i = 1'b0; dp_last_i = 1'b0;
    #1;
    n_cmp++; if (rsp_valid_o !== 1'b1) begin n_mis++; $display("FAIL err_rsp_valid: got %b exp 1", rsp_valid_o); end
    n_cmp++; if (rsp_err_o !== 1'b1) begin n_mis++; $display("FAIL err_rsp_err: got %b exp 1", rsp_err_o); end
    rsp_ready_i = 1'b1;
    cyc();
    rsp_ready_i = 1'b0;
    meta_valid_i = 1'b1; meta_addr_i = 32'h4100; obi_gnt_i = 1'b1;
    #1;
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_mis++; $display("FAIL err_rsp_taken: got %b exp 0", rsp_valid_o); end
    cyc();
    meta_valid_i = 1'b0; obi_gnt_i = 1'b0;
    obi_rvalid_i = 1'b1; obi_rdata_i = 32'hB0B0B0B0; obi_err_i = 1'b0;
    cyc();
    obi_rvalid_i = 1'b0;
    dp_valid_i = 1'b1; dp_last_i = 1'b1;
    #1;
    n_cmp++; if (dp_ready_o !== 1'b1) begin n_mis++; $display("FAIL err_next_beat: got %b exp 1", dp_ready_o); end
    cyc();
    dp_valid_i = 1'b0; dp_last_i = 1'b0;
    #1;
    n_cmp++; if (rsp_valid_o !== 1'b1) begin n_mis++; $display("FAIL err_next_rsp_valid: got %b exp 1", rsp_valid_o); end
    n_cmp++; if (rsp_err_o !== 1'b0) begin n_mis++; $display("FAIL err_next_rsp_err: got %b exp 0", rsp_err_o); end
    rsp_ready_i = 1'b1;
    cyc();
    rsp_ready_i = 1'b0;
    #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL err_idle: got %b exp 0", busy_o); end
  endtask

  task automatic test_back_to_back();
    cyc();
    meta_valid_i = 1'b1; meta_addr_i = 32'h5000; obi_gnt_i = 1'b1;
    cyc();
    meta_addr_i = 32'h6000;
    obi_rvalid_i = 1'b1; obi_rdata_i = 32'hC0C0C0C0; obi_err_i = 1'b0;
    cyc();
    meta_valid_i = 1'b0; obi_gnt_i = 1'b0;
    obi_rdata_i = 32'hC1C1C1C1;
    dp_valid_i = 1'b1; dp_last_i = 1'b1; rsp_ready_i = 1'b0;
    #1;
    n_cmp++; if (dp_ready_o !== 1'b1) begin n_mis++; $display("FAIL b2b_first: got %b exp 1", dp_ready_o); end
    cyc();
    obi_rvalid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (rsp_valid_o !== 1'b1) begin n_mis++; $display("FAIL b2b_hold_rsp[%0d]: got %b exp 1", i, rsp_valid_o); end
      n_cmp++; if (dp_ready_o !== 1'b0) begin n_mis++; $display("FAIL b2b_stall[%0d]: got %b exp 0", i, dp_ready_o); end
      cyc();
    end
    rsp_ready_i = 1'b1;
    #1;
    n_cmp++; if (dp_ready_o !== 1'b1) begin n_mis++; $display("FAIL b2b_second: got %b exp 1", dp_ready_o); end
    n_cmp++; if (rsp_valid_o !== 1'b1) begin n_mis++; $display("FAIL b2b_first_rsp: got %b exp 1", rsp_valid_o); end
    cyc();
    #1;
    n_cmp++; if (rsp_valid_o !== 1'b1) begin n_mis++; $display("FAIL b2b_reload: got %b exp 1", rsp_valid_o); end
    n_cmp++; if (rsp_err_o !== 1'b0) begin n_mis++; $display("FAIL b2b_rsp_err: got %b exp 0", rsp_err_o); end
    cyc();
    rsp_ready_i = 1'b0; dp_valid_i = 1'b0; dp_last_i = 1'b0;
    #1;
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_mis++; $display("FAIL b2b_done: got %b exp 0", rsp_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL b2b_idle: got %b exp 0", busy_o); end
  endtask

  task automatic test_empty_mask();
    cyc();
    meta_valid_i = 1'b1; meta_addr_i = 32'h7000; obi_gnt_i = 1'b1;
    cyc();
    meta_valid_i = 1'b0; obi_gnt_i = 1'b0;
    obi_rvalid_i = 1'b1; obi_rdata_i = 32'h12345678;
    cyc();
    obi_rvalid_i = 1'b0;
    dp_valid_i = 1'b1; dp_offset_i = 2'd2; dp_tailer_i = 2'd2; dp_last_i = 1'b1;
    #1;
    n_cmp++; if (buffer_in_valid_o !== 4'b0000) begin n_mis++; $display("FAIL empty_valid: got %b exp 0000", buffer_in_valid_o); end
    n_cmp++; if (dp_ready_o !== 1'b1) begin n_mis++; $display("FAIL empty_complete: got %b exp 1", dp_ready_o); end
    cyc();
    dp_valid_i = 1'b0; dp_offset_i = 2'd0; dp_tailer_i = 2'd0; dp_last_i = 1'b0;
    #1;
    n_cmp++; if (rsp_valid_o !== 1'b1) begin n_mis++; $display("FAIL empty_rsp: got %b exp 1", rsp_valid_o); end
    rsp_ready_i = 1'b1;
    cyc();
    rsp_ready_i = 1'b0;
    #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL empty_idle: got %b exp 0", busy_o); end
  endtask

  task automatic test_reset_midflight();
    cyc();
    meta_valid_i = 1'b1; meta_addr_i = 32'h8000; obi_gnt_i = 1'b1;
    repeat (3) cyc();
    obi_gnt_i = 1'b0;
    dp_valid_i = 1'b1;
    #1;
    n_cmp++; if (busy_o !== 1'b1) begin n_mis++; $display("FAIL mid_busy: got %b exp 1", busy_o); end
    n_cmp++; if (obi_req_o !== 1'b1) begin n_mis++; $display("FAIL mid_req: got %b exp 1", obi_req_o); end
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (obi_req_o !== 1'b0) begin n_mis++; $display("FAIL mid_rst_req: got %b exp 0", obi_req_o); end
    n_cmp++; if (meta_ready_o !== 1'b0) begin n_mis++; $display("FAIL mid_rst_meta_ready: got %b exp 0", meta_ready_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL mid_rst_busy: got %b exp 0", busy_o); end
    n_cmp++; if (dp_ready_o !== 1'b0) begin n_mis++; $display("FAIL mid_rst_dp_ready: got %b exp 0", dp_ready_o); end
    n_cmp++; if (buffer_in_valid_o !== 4'b0000) begin n_mis++; $display("FAIL mid_rst_buf_valid: got %b exp 0000", buffer_in_valid_o); end
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_mis++; $display("FAIL mid_rst_rsp_valid: got %b exp 0", rsp_valid_o); end
    cyc();
    idle_inputs();
    rst_ni = 1'b1;
    #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL mid_post_busy: got %b exp 0", busy_o); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_outstanding();
    test_partial_lanes();
    test_error_accum();
    test_back_to_back();
    test_empty_mask();
    test_reset_midflight();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
